// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty levels,
// standard or first-word-fall-through read, fill count, synchronous flush and sticky error flags.
module sync_fifo_flex #(
  parameter int D_SIZE   = 8,
  parameter int A_SIZE   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              w_inc,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              rinc,
  output logic [D_SIZE-1:0] rdata,
  output logic              w_full,
  output logic              rempty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [A_SIZE:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << A_SIZE;

  if (A_SIZE < 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1)
  begin : g_param_err
    $error("sync_fifo_flex: illegal parameters A_SIZE=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           A_SIZE, AF_LEVEL, AE_LEVEL);
  end

  localparam logic [A_SIZE:0] C_DEPTH = (A_SIZE+1)'(DEPTH);
  localparam logic [A_SIZE:0] C_AF    = (A_SIZE+1)'(AF_LEVEL);
  localparam logic [A_SIZE:0] C_AE    = (A_SIZE+1)'(AE_LEVEL);

  logic [D_SIZE-1:0] r_mem [DEPTH];
  logic [A_SIZE:0]   r_wptr;
  logic [A_SIZE:0]   r_rptr;
  logic [A_SIZE:0]   r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [D_SIZE-1:0] w_head;

  // Flags decode from the registered count so they move on the same edge as count.
  assign w_full       = (r_count == C_DEPTH);
  assign rempty       = (r_count == '0);
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  assign w_wr_en = w_inc & ~w_full & ~flush;
  assign w_rd_en = rinc & ~rempty & ~flush;
  assign w_head  = r_mem[r_rptr[A_SIZE-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en && rstn) begin
      r_mem[r_wptr[A_SIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_inc && w_full) r_ovf <= 1'b1;
      if (rinc && rempty)  r_unf <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; zero while empty keeps the output stable.
    assign rdata = rempty ? '0 : w_head;
  end else begin : g_std
    logic [D_SIZE-1:0] r_rdata;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rdata <= '0;
      end else if (w_rd_en) begin
        r_rdata <= w_head;
      end
    end
    assign rdata = r_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-mode and an FWFT-mode instance driven side by side.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_flush, s_w_inc, s_rinc;
  logic [7:0] s_wdata, s_rdata;
  logic       s_w_full, s_rempty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;
  logic       f_flush, f_w_inc, f_rinc;
  logic [7:0] f_wdata, f_rdata;
  logic       f_w_full, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d, last_rd;
  int m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_flex #(.FWFT(0)) u_std (
    .clk(clk), .rstn(rstn), .flush(s_flush), .w_inc(s_w_inc), .wdata(s_wdata),
    .rinc(s_rinc), .rdata(s_rdata), .w_full(s_w_full), .rempty(s_rempty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_flex #(.FWFT(1)) u_fw (
    .clk(clk), .rstn(rstn), .flush(f_flush), .w_inc(f_w_inc), .wdata(f_wdata),
    .rinc(f_rinc), .rdata(f_rdata), .w_full(f_w_full), .rempty(f_rempty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_push(input logic [7:0] d);
    s_w_inc = 1'b1; s_wdata = d;
    tick();
    s_w_inc = 1'b0;
    sb.push_back(d);
  endtask

  task automatic s_pop_check(input string tag);
    s_rinc = 1'b1;
    tick();
    s_rinc = 1'b0;
    exp_d = sb.pop_front();
    check(tag, s_rdata, exp_d);
  endtask

  task automatic s_do_flush();
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    sb.delete();
  endtask

  initial begin
    rstn = 1'b0;
    s_flush = 0; s_w_inc = 0; s_rinc = 0; s_wdata = '0;
    f_flush = 0; f_w_inc = 0; f_rinc = 0; f_wdata = '0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    tick();

    // Reset / idle
    check("rst_rempty", s_rempty, 1);
    check("rst_wfull", s_w_full, 0);
    check("rst_count", s_count, 0);
    check("rst_ae", s_ae, 1);
    check("rst_af", s_af, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_ovf", s_ovf, 0);
    check("rst_unf", s_unf, 0);
    check("rst_f_flags", {f_rempty, f_w_full, f_af, f_ae, f_ovf, f_unf}, 6'b100100);
    check("rst_f_rdata", f_rdata, 0);

    // FWFT instance
    f_w_inc = 1; f_wdata = 8'hA5; tick(); f_w_inc = 0;
    check("fw_rempty", f_rempty, 0);
    check("fw_head_a5", f_rdata, 8'hA5);
    f_w_inc = 1; f_wdata = 8'h3C; tick(); f_w_inc = 0;
    check("fw_head_kept", f_rdata, 8'hA5);
    check("fw_count2", f_count, 2);
    f_rinc = 1; tick(); f_rinc = 0;
    check("fw_head_3c", f_rdata, 8'h3C);
    check("fw_count1", f_count, 1);
    f_rinc = 1; tick(); f_rinc = 0;
    check("fw_empty", f_rempty, 1);
    check("fw_unf", f_unf, 0);

    // Fill with threshold tracking
    for (int k = 1; k <= 16; k++) begin
      s_push(8'($urandom_range(0, 255)));
      check("fill_count", s_count, k);
      check("fill_af", s_af, (k >= 12));
      check("fill_ae", s_ae, (k <= 4));
      check("fill_full", s_w_full, (k == 16));
    end
    s_w_inc = 1; s_wdata = 8'hEE; tick(); s_w_inc = 0;
    check("ovf_set", s_ovf, 1);
    check("ovf_count", s_count, 16);

    for (int k = 0; k < 16; k++) s_pop_check("drain_rdata");
    check("drain_empty", s_rempty, 1);
    last_rd = s_rdata;
    s_rinc = 1; tick(); s_rinc = 0;
    check("unf_set", s_unf, 1);
    check("unf_rdata_hold", s_rdata, last_rd);
    check("unf_count", s_count, 0);

    // Simultaneous read+write at count 7
    s_do_flush();
    check("flush_flags", {s_ovf, s_unf}, 2'b00);
    for (int k = 0; k < 7; k++) s_push(8'h10 + 8'(k));
    s_w_inc = 1; s_wdata = 8'h99; s_rinc = 1; tick(); s_w_inc = 0; s_rinc = 0;
    sb.push_back(8'h99);
    exp_d = sb.pop_front();
    check("both7_rdata", s_rdata, exp_d);
    check("both7_count", s_count, 7);
    for (int k = 0; k < 7; k++) s_pop_check("both7_order");

    // Simultaneous at full: only the read goes through
    for (int k = 0; k < 16; k++) s_push(8'h40 + 8'(k));
    s_w_inc = 1; s_wdata = 8'hBB; s_rinc = 1; tick(); s_w_inc = 0; s_rinc = 0;
    exp_d = sb.pop_front();
    check("bothfull_rdata", s_rdata, exp_d);
    check("bothfull_count", s_count, 15);
    check("bothfull_ovf", s_ovf, 1);

    // Flush at count 9 with overflow set, concurrent write dropped
    for (int k = 0; k < 6; k++) s_pop_check("pre_flush_rd");
    check("pre_flush_count", s_count, 9);
    last_rd = s_rdata;
    s_flush = 1; s_w_inc = 1; s_wdata = 8'hCD; tick(); s_flush = 0; s_w_inc = 0;
    sb.delete();
    check("flush_count", s_count, 0);
    check("flush_rempty", s_rempty, 1);
    check("flush_ovf", s_ovf, 0);
    check("flush_rdata_hold", s_rdata, last_rd);
    tick();
    check("flush_wr_dropped", s_count, 0);

    // Simultaneous at empty: only the write goes through
    s_w_inc = 1; s_wdata = 8'h6E; s_rinc = 1; tick(); s_w_inc = 0; s_rinc = 0;
    sb.push_back(8'h6E);
    check("bothempty_count", s_count, 1);
    check("bothempty_unf", s_unf, 1);
    check("bothempty_rdata", s_rdata, last_rd);
    s_pop_check("bothempty_word");

    // Random push/pop across pointer wrap
    s_do_flush();
    m_ovf = 0; m_unf = 0;
    for (int c = 0; c < 3 * 16 + 5; c++) begin
      logic w, r, acc_w, acc_r;
      logic [7:0] d;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      d = 8'($urandom_range(0, 255));
      acc_w = w && (sb.size() < 16);
      acc_r = r && (sb.size() > 0);
      if (w && !acc_w) m_ovf = 1;
      if (r && !acc_r) m_unf = 1;
      if (acc_r) exp_d = sb.pop_front();
      if (acc_w) sb.push_back(d);
      s_w_inc = w; s_rinc = r; s_wdata = d;
      tick();
      s_w_inc = 0; s_rinc = 0;
      check("rnd_count", s_count, sb.size());
      if (acc_r) check("rnd_rdata", s_rdata, exp_d);
      check("rnd_flags", {s_ovf, s_unf}, {m_ovf[0], m_unf[0]});
    end

    // Asynchronous reset mid-stream
    s_do_flush();
    s_push(8'h5A);
    s_push(8'h77);
    s_pop_check("pre_rst_rd");
    s_w_inc = 1; s_wdata = 8'h12; s_rinc = 1;
    #2 rstn = 1'b0;
    #1;
    check("arst_count", s_count, 0);
    check("arst_rempty", s_rempty, 1);
    check("arst_rdata", s_rdata, 0);
    check("arst_flags", {s_w_full, s_af, s_ae, s_ovf, s_unf}, 5'b00100);
    tick();
    check("arst_ignored", s_count, 0);
    s_w_inc = 0; s_rinc = 0;
    #2 rstn = 1'b1;
    tick();
    check("arst_release", {s_rempty, s_count}, {1'b1, 5'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO family.
- Configurable width/depth, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, fill count, synchronous flush, sticky overflow/underflow error flags.
- Used as the local buffering stage in front of/behind the async FIFO and in single-domain datapaths.

Parameters:
D_SIZE, 8, data width in bits
A_SIZE, 4, address width; DEPTH = 2**A_SIZE entries
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal 1..DEPTH
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal 0..DEPTH-1
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO contents and error flags
w_inc  input  1  write request
wdata  input  D_SIZE  write data
rinc  input  1  read request (pop)
rdata  output  D_SIZE  read data
w_full  output  1  count == DEPTH
rempty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  A_SIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rstn low, async, no clock needed):
  - wptr = rptr = 0; count = 0; rempty = 1; w_full = 0; almost_empty = 1; almost_full = 0; overflow = underflow = 0; rdata = 0.
  - Memory is not reset. While rstn is low, all inputs are ignored.
- Pointers are A_SIZE+1 bits and wrap modulo 2*DEPTH. count = wptr - rptr, held in a register. All flags decode combinationally from the registered count/pointers, so they change on the same edge as count.
- Write accepted = w_inc & !w_full & !flush:
  - mem[wptr] <= wdata; wptr + 1.
  - w_inc while w_full: data dropped, overflow <= 1.
- Read accepted = rinc & !rempty & !flush:
  - rptr + 1.
  - rinc while rempty: no pointer change, underflow <= 1, rdata unchanged.
- Accept decisions use flag values before the edge:
  - Full with simultaneous w_inc+rinc: only the read is accepted; overflow is set.
  - Empty with simultaneous w_inc+rinc: only the write is accepted; underflow is set.
  - Otherwise, simultaneous accepted read and write leaves count unchanged.
- Standard mode (FWFT=0):
  - Accepted read registers mem[rptr] into rdata at that edge, so data is valid the cycle after rinc is sampled (1-cycle latency).
  - rdata holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] whenever rempty = 0; the head word is visible without a request, and rinc acknowledges and pops it.
  - Next word appears on the edge that accepts the read.
  - rdata is undefined-but-stable while rempty = 1 (bench must not check it).
- Write-to-read: a word written at edge N deasserts rempty after edge N. In FWFT it is visible on rdata after edge N; in standard mode it is readable with rinc from then.
- flush (synchronous, highest priority after reset):
  - wptr = rptr = 0, count = 0, overflow = underflow = 0.
  - Concurrent w_inc/rinc are ignored and do not set error flags.
  - rdata holds in standard mode.
- Error flags are cleared only by rstn or flush.
- Parameter violation (AF_LEVEL or AE_LEVEL out of range, A_SIZE < 1) must raise an elaboration-time error.

Test Plan:
- Reset/idle (D_SIZE=8, A_SIZE=4): after rstn release, expect rempty=1, w_full=0, count=0, almost_empty=1, almost_full=0, rdata=0.
- Fill/drain, standard mode: write 16 random words.
  - count reaches 16, w_full=1; almost_full rises on the 12th write, almost_empty falls on the 5th.
  - 17th write sets overflow=1 with count staying 16.
  - Read 16: each rdata matches the scoreboard one cycle after rinc; rempty=1 at end.
  - One extra rinc sets underflow=1.
- FWFT mode: write 0xA5 → after that edge rempty=0 and rdata=0xA5 with no rinc. Write 0x3C, pulse rinc → rdata=0x3C next edge; second rinc → rempty=1.
- Simultaneous ops:
  - At count=7, w_inc+rinc → count stays 7, order preserved.
  - At full, both → count 15, overflow=1.
  - At empty, both → count 1, underflow=1.
- Flush: at count=9 with overflow=1, assert flush with w_inc=1 → next cycle count=0, rempty=1, overflow=0, write dropped.
- Wrap-around and async reset: run 3×DEPTH+5 random push/pop cycles with the scoreboard matching throughout. Assert rstn low mid-stream between clock edges → outputs go to reset values immediately.
